// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package mips_fetch_pkg;

   localparam int MIPS_WORD_W      = 32;
   localparam int MIPS_INSTR_BYTES = 4;

   localparam logic [MIPS_WORD_W-1:0] MIPS_NOP = 32'h0000_0000;

   typedef struct packed {
      logic [MIPS_WORD_W-1:0] pc;
      logic [MIPS_WORD_W-1:0] word;
   } fetch_entry_t;

   function automatic logic [MIPS_WORD_W-1:0] word_align(
      input logic [MIPS_WORD_W-1:0] a
   );
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// Small in-order FIFO with synchronous flush; used for the
// instruction queue and for the in-flight address queue.
module mips_fetch_fifo
   import mips_fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  head,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!nrst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Storage needs no reset; outputs are qualified by count.
   always_ff @(posedge clk) begin
      if (nrst && !flush && push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS fetch stage: PC, pipelined imem requests, in-order queue.
// Optional MIPS_FETCH_BYPASS_EN forwards responses into an empty queue.
module mips_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   redirect,
   input  logic [MIPS_WORD_W-1:0] redirect_pc,
   output logic                   imem_req,
   output logic [MIPS_WORD_W-1:0] imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [MIPS_WORD_W-1:0] imem_rdata,
   output logic                   inst_valid,
   output logic [MIPS_WORD_W-1:0] inst,
   output logic [MIPS_WORD_W-1:0] inst_pc,
   input  logic                   inst_ready
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

   logic [MIPS_WORD_W-1:0] fetch_pc;
   logic [CW-1:0]          outstanding;
   logic [CW-1:0]          discard;
   logic [CW-1:0]          q_count;
   logic [CW-1:0]          pcq_count;
   logic [MIPS_WORD_W-1:0] pcq_head;
   fetch_entry_t           q_head;
   fetch_entry_t           q_din;
   logic                   rv;
   logic                   keep;
   logic                   gnt;
   logic                   q_push;
   logic                   q_pop;
   logic                   pcq_pop;

   // Responses with nothing outstanding are protocol errors and ignored.
   assign rv   = imem_rvalid && (outstanding != '0);
   assign keep = rv && (discard == '0) && !redirect;

   assign imem_req = nrst && !redirect &&
                     (({1'b0, q_count} + {1'b0, outstanding}) < FULL);
   assign imem_addr = fetch_pc;
   assign gnt       = imem_req && imem_gnt;

   assign pcq_pop = keep && (pcq_count != '0);
   assign q_din   = '{pc: pcq_head, word: imem_rdata};

`ifdef MIPS_FETCH_BYPASS_EN
   logic byp;

   assign byp        = keep && (q_count == '0);
   assign inst_valid = (q_count != '0) || byp;
   assign inst       = byp ? imem_rdata :
                       (q_count != '0) ? q_head.word : MIPS_NOP;
   assign inst_pc    = byp ? pcq_head :
                       (q_count != '0) ? q_head.pc : '0;
   assign q_pop      = (q_count != '0) && inst_ready;
   assign q_push     = keep && !(byp && inst_ready);
`else
   assign inst_valid = (q_count != '0);
   assign inst       = inst_valid ? q_head.word : MIPS_NOP;
   assign inst_pc    = inst_valid ? q_head.pc : '0;
   assign q_pop      = inst_valid && inst_ready;
   assign q_push     = keep;
`endif

   always_ff @(posedge clk) begin
      if (!nrst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else if (redirect) begin
         // Everything still in flight after this cycle is stale.
         fetch_pc    <= word_align(redirect_pc);
         outstanding <= outstanding - CW'(rv);
         discard     <= outstanding - CW'(rv);
      end else begin
         if (gnt)
            fetch_pc <= fetch_pc + 32'(MIPS_INSTR_BYTES);
         outstanding <= outstanding + CW'(gnt) - CW'(rv);
         if (rv && (discard != '0))
            discard <= discard - CW'(1);
      end
   end

   mips_fetch_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(fetch_entry_t))
   ) u_inst_q (
      .clk   (clk),
      .nrst  (nrst),
      .flush (redirect),
      .push  (q_push),
      .pop   (q_pop),
      .din   (q_din),
      .head  (q_head),
      .count (q_count)
   );

   mips_fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (MIPS_WORD_W)
   ) u_pc_q (
      .clk   (clk),
      .nrst  (nrst),
      .flush (redirect),
      .push  (gnt),
      .pop   (pcq_pop),
      .din   (fetch_pc),
      .head  (pcq_head),
      .count (pcq_count)
   );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_mips_fetch_unit;
   import mips_fetch_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        nrst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   always #5 clk = ~clk;

   mips_fetch_unit #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0]  m_fpc = RESET_PC;
   fetch_entry_t m_q[$];
   logic [31:0]  m_pcq[$];
   int           m_out  = 0;
   int           m_disc = 0;
   bit           m_init = 0;

   // Memory model
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t mem_q[$];
   int    cyc = 0;
   int    lat = 1;
   bit    spurious_en = 0;

   // Last sampled outputs
   logic        o_req, o_valid, o_gnt, o_rv;
   logic [31:0] o_addr, o_pc, o_inst;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic bit m_req_f();
      return nrst && !redirect && ((m_q.size() + m_out) < DEPTH);
   endfunction

   // One clock cycle: drive memory, compare, then advance model.
   task automatic cycle();
      bit          grant;
      bit          real_resp;
      bit          rv;
      real_resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      if (real_resp) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_q[0].addr ^ KEY;
      end else if (spurious_en && m_out == 0 &&
                   $urandom_range(0, 7) == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = $urandom;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end
      #1;
      o_req   = imem_req;
      o_addr  = imem_addr;
      o_valid = inst_valid;
      o_pc    = inst_pc;
      o_inst  = inst;
      o_gnt   = imem_gnt;
      o_rv    = imem_rvalid;
      if (m_init) begin
         chk("imem_req", {31'b0, imem_req}, {31'b0, m_req_f()});
         chk("imem_addr", imem_addr, m_fpc);
         chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_q.size() > 0});
         if (m_q.size() > 0) begin
            chk("inst_pc", inst_pc, m_q[0].pc);
            chk("inst", inst, m_q[0].word);
            chk("inst_word_rule", inst, inst_pc ^ KEY);
         end
      end
      grant = m_req_f() && imem_gnt;
      @(posedge clk);
      if (!nrst) begin
         mem_q.delete();
      end else begin
         if (real_resp)
            void'(mem_q.pop_front());
         if (grant)
            mem_q.push_back('{addr: m_fpc, due: cyc + lat});
      end
      if (!nrst) begin
         m_q.delete();
         m_pcq.delete();
         m_out  = 0;
         m_disc = 0;
         m_fpc  = RESET_PC;
         m_init = 1;
      end else begin
         rv = imem_rvalid && (m_out > 0);
         if (inst_ready && m_q.size() > 0)
            void'(m_q.pop_front());
         if (redirect) begin
            m_q.delete();
            m_pcq.delete();
            if (rv) m_out--;
            m_disc = m_out;
            m_fpc  = redirect_pc & ~32'h3;
         end else begin
            if (rv) begin
               m_out--;
               if (m_disc > 0)
                  m_disc--;
               else
                  m_q.push_back('{pc: m_pcq.pop_front(), word: imem_rdata});
            end
            if (grant) begin
               m_pcq.push_back(m_fpc);
               m_fpc = m_fpc + 32'd4;
               m_out++;
            end
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      nrst     = 1'b0;
      redirect = 1'b0;
      cycle();
      nrst = 1'b1;
   endtask

   // Run until inst_valid is seen, bounded; returns pc.
   task automatic wait_valid(input string name, output logic [31:0] pc);
      bit found = 0;
      pc = 32'hDEAD_BEEF;
      for (int k = 0; k < 20 && !found; k++) begin
         cycle();
         if (o_valid) begin
            found = 1;
            pc    = o_pc;
         end
      end
      chk({name, "_timeout"}, {31'b0, found}, 32'd1);
   endtask

   initial begin
      logic [31:0] pcs[$];
      logic [31:0] pc;
      int          first_g;
      int          first_v;
      int          grants;

      nrst        = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_gnt    = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      inst_ready  = 1'b1;
      @(negedge clk);

      // Reset values
      cycle();
      cycle();
      chk("rst_req", {31'b0, o_req}, 32'd0);
      chk("rst_addr", o_addr, RESET_PC);
      chk("rst_valid", {31'b0, o_valid}, 32'd0);
      chk("rst_inst", o_inst, 32'h0);
      chk("rst_pc", o_pc, 32'h0);

      // Zero-wait streaming
      nrst    = 1'b1;
      first_g = -1;
      first_v = -1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         if (first_g < 0 && o_req && o_gnt) first_g = k;
         if (first_v < 0 && o_valid) first_v = k;
         if (o_valid) pcs.push_back(o_pc);
      end
      chk("first_grant_cycle", first_g, 0);
      chk("grant_to_inst_lat", first_v - first_g, 2);
      chk("stream_len", pcs.size(), 6);
      for (int i = 0; i < 4; i++)
         if (i < pcs.size()) chk("stream_pc", pcs[i], 32'(i * 4));

      // Back-pressure
      inst_ready = 1'b0;
      do_reset();
      grants = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         grants += int'(o_req && o_gnt);
      end
      chk("bp_grants", grants, DEPTH);
      chk("bp_req_low", {31'b0, o_req}, 32'd0);
      chk("bp_valid", {31'b0, o_valid}, 32'd1);
      chk("bp_pc", o_pc, 32'h0);
      chk("bp_inst", o_inst, KEY);
      inst_ready = 1'b1;
      cycle();
      cycle();
      chk("bp_resume_req", {31'b0, o_req}, 32'd1);

      // Redirect with three responses in flight
      do_reset();
      lat = 3;
      cycle();
      cycle();
      cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_1002;
      cycle();
      chk("redir_req_low", {31'b0, o_req}, 32'd0);
      redirect = 1'b0;
      cycle();
      chk("redir_req", {31'b0, o_req}, 32'd1);
      chk("redir_addr", o_addr, 32'h0000_1000);
      wait_valid("redir_inst", pc);
      chk("redir_inst_pc", pc, 32'h0000_1000);

      // Redirect coinciding with a handshake and a response
      lat = 1;
      do_reset();
      for (int k = 0; k < 5; k++) cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_2000;
      cycle();
      chk("hs_valid", {31'b0, o_valid}, 32'd1);
      chk("hs_rvalid", {31'b0, o_rv}, 32'd1);
      redirect = 1'b0;
      wait_valid("hs_after", pc);
      chk("hs_next_pc", pc, 32'h0000_2000);
      cycle();
      chk("hs_next_pc2", o_pc, 32'h0000_2004);

      // Address wrap
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      cycle();
      redirect = 1'b0;
      cycle();
      chk("wrap_addr0", o_addr, 32'hFFFF_FFFC);
      cycle();
      chk("wrap_addr1", o_addr, 32'h0000_0000);
      wait_valid("wrap_inst", pc);
      chk("wrap_inst_pc", pc, 32'hFFFF_FFFC);
      for (int k = 0; k < 3; k++) cycle();

      // Mid-stream reset
      nrst = 1'b0;
      cycle();
      chk("mrst_req", {31'b0, o_req}, 32'd0);
      nrst = 1'b1;
      cycle();
      chk("mrst_req1", {31'b0, o_req}, 32'd1);
      chk("mrst_addr", o_addr, RESET_PC);
      chk("mrst_valid", {31'b0, o_valid}, 32'd0);
      chk("mrst_inst", o_inst, 32'h0);
      chk("mrst_pc", o_pc, 32'h0);

      // Randomized traffic
      spurious_en = 1;
      for (int k = 0; k < 4000; k++) begin
         imem_gnt    = ($urandom_range(0, 3) != 0);
         inst_ready  = ($urandom_range(0, 3) != 0);
         lat         = $urandom_range(1, 4);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ?
                       32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
         nrst        = ($urandom_range(0, 199) != 0);
         cycle();
      end
      nrst     = 1'b1;
      redirect = 1'b0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
